// File: rtl/tetris_pkg.sv
// Shared board geometry, colours and arbiter enums for the Tetris board RAM path.
package tetris_pkg;

    localparam int unsigned BOARD_COLS  = 10;
    localparam int unsigned BOARD_ROWS  = 20;
    localparam int unsigned BOARD_DEPTH = BOARD_COLS * BOARD_ROWS;

    localparam logic [7:0] COLOUR_BG = 8'h00;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_CLR,
        OWN_GAME
    } owner_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } arb_state_t;

endpackage

// File: rtl/board_clear_seq.sv
// Board-clear sequencer: walks addresses 0..DEPTH-1 once per start, pausing on stall.
module board_clear_seq
    import tetris_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = BOARD_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    arb_state_t        state;
    logic [ADDR_W-1:0] cnt;

    // A clear write happens in every CLEAR cycle the display does not claim.
    assign wr_en   = (state == ST_CLEAR) && !stall;
    assign wr_addr = cnt;

    // IDLE/CLEAR state, address counter and registered busy/done flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (!stall) begin
                        if (cnt == LAST_ADDR) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/board_ram_arbiter.sv
// Single-port board RAM arbiter: display > clear sequencer > game, with starvation flag.
module board_ram_arbiter
    import tetris_pkg::*;
#(
    parameter int unsigned              ADDR_W       = 8,
    parameter int unsigned              DATA_W       = 8,
    parameter int unsigned              DEPTH        = BOARD_DEPTH,
    parameter logic [DATA_W-1:0]        CLR_VALUE    = DATA_W'(COLOUR_BG),
    parameter int unsigned              STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_rvalid,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_gnt,
    output logic              game_rvalid,
    output logic              game_starved,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned         STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    owner_t            owner;
    logic              clr_wr_en;
    logic [ADDR_W-1:0] clr_wr_addr;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_nxt;
    logic              rdata_unused;

    // Read data goes straight from the RAM to its consumers; nothing here needs it.
    assign rdata_unused = ^ram_rdata;

    board_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear (
        .clk     (clk),
        .rst     (rst),
        .start   (clr_start),
        .stall   (disp_req),
        .busy    (clr_busy),
        .done    (clr_done),
        .wr_en   (clr_wr_en),
        .wr_addr (clr_wr_addr)
    );

    // Per-cycle owner; clr_wr_en is already gated by disp_req so a CLEAR cycle never reaches the game.
    always_comb begin
        owner = OWN_NONE;
        if (rst)            owner = OWN_NONE;
        else if (disp_req)  owner = OWN_DISP;
        else if (clr_wr_en) owner = OWN_CLR;
        else if (clr_busy)  owner = OWN_NONE;
        else if (game_req)  owner = OWN_GAME;
    end

    // RAM port mux driven by the current owner.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (owner)
            OWN_DISP: begin
                ram_en   = 1'b1;
                ram_addr = disp_addr;
            end
            OWN_CLR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_wr_addr;
                ram_wdata = CLR_VALUE;
            end
            OWN_GAME: begin
                ram_en    = 1'b1;
                ram_we    = game_we;
                ram_addr  = game_addr;
                ram_wdata = game_wdata;
            end
            default: ;
        endcase
    end

    assign game_gnt = (owner == OWN_GAME);

    // Starvation count: consecutive cycles of an ungranted game request, saturating.
    always_comb begin
        starve_nxt = '0;
        if (game_req && !game_gnt) begin
            starve_nxt = (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + STARVE_W'(1);
        end
    end

    // Registered read-return strobes and starvation state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_rvalid  <= 1'b0;
            game_rvalid  <= 1'b0;
            starve_cnt   <= '0;
            game_starved <= 1'b0;
        end else begin
            disp_rvalid  <= (owner == OWN_DISP);
            game_rvalid  <= (owner == OWN_GAME) && !game_we;
            starve_cnt   <= starve_nxt;
            game_starved <= (starve_nxt == STARVE_MAX);
        end
    end

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Bench for board_ram_arbiter: vector table, directed clear/starve/reset sequences, random traffic.
module tb_board_ram_arbiter;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int          DEPTH = 200;
    localparam int          LIMIT = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_rvalid;
    logic          game_req;
    logic          game_we;
    logic [AW-1:0] game_addr;
    logic [DW-1:0] game_wdata;
    logic          game_gnt;
    logic          game_rvalid;
    logic          game_starved;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    board_ram_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .DEPTH        (DEPTH),
        .CLR_VALUE    (8'h00),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_rvalid  (disp_rvalid),
        .game_req     (game_req),
        .game_we      (game_we),
        .game_addr    (game_addr),
        .game_wdata   (game_wdata),
        .game_gnt     (game_gnt),
        .game_rvalid  (game_rvalid),
        .game_starved (game_starved),
        .clr_start    (clr_start),
        .clr_busy     (clr_busy),
        .clr_done     (clr_done),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    // Board RAM: synchronous single port, one-cycle read latency.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Reference model: pending clear addresses as a queue, wait count, shadow board contents.
    int            clr_q[$];
    int            wait_cnt;
    bit            exp_done, exp_drv, exp_grv;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] shadow [256];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model mid-cycle, advance the model.
    task automatic cycle(input bit dr, input int da, input bit gr, input bit gw,
                         input int ga, input int gd, input bit cs, output bit gnt_o);
        bit idle, gnt_e, en_e, we_e;
        int addr_e, wd_e;
        @(posedge clk);
        #1;
        disp_req   = dr;
        disp_addr  = AW'(da);
        game_req   = gr;
        game_we    = gw;
        game_addr  = AW'(ga);
        game_wdata = DW'(gd);
        clr_start  = cs;
        #3;
        chk("clr_busy", {31'd0, clr_busy}, {31'd0, clr_q.size() != 0});
        chk("clr_done", {31'd0, clr_done}, {31'd0, exp_done});
        chk("disp_rvalid", {31'd0, disp_rvalid}, {31'd0, exp_drv});
        chk("game_rvalid", {31'd0, game_rvalid}, {31'd0, exp_grv});
        if (exp_drv || exp_grv) chk("rdata", {24'd0, ram_rdata}, {24'd0, exp_rdata});
        chk("game_starved", {31'd0, game_starved}, {31'd0, wait_cnt == LIMIT});

        idle = (clr_q.size() == 0);
        gnt_e = 0; en_e = 0; we_e = 0; addr_e = 0; wd_e = 0;
        if (dr) begin
            en_e = 1; addr_e = da;
        end else if (!idle) begin
            en_e = 1; we_e = 1; addr_e = clr_q[0]; wd_e = 0;
        end else if (gr) begin
            gnt_e = 1; en_e = 1; we_e = gw; addr_e = ga; wd_e = gd;
        end
        chk("game_gnt", {31'd0, game_gnt}, {31'd0, gnt_e});
        chk("ram_en", {31'd0, ram_en}, {31'd0, en_e});
        if (en_e) begin
            chk("ram_we", {31'd0, ram_we}, {31'd0, we_e});
            chk("ram_addr", {24'd0, ram_addr}, addr_e);
        end
        if (we_e) chk("ram_wdata", {24'd0, ram_wdata}, wd_e);

        exp_drv = dr;
        exp_grv = gnt_e && !gw;
        if (en_e && !we_e) exp_rdata = shadow[addr_e];
        if (en_e && we_e)  shadow[addr_e] = DW'(wd_e);
        exp_done = 0;
        if (!idle && !dr) begin
            void'(clr_q.pop_front());
            if (clr_q.size() == 0) exp_done = 1;
        end
        if (idle && cs) for (int i = 0; i < DEPTH; i++) clr_q.push_back(i);
        if (gr && !gnt_e) wait_cnt = (wait_cnt < LIMIT) ? wait_cnt + 1 : LIMIT;
        else              wait_cnt = 0;
        gnt_o = gnt_e;
    endtask

    // Asynchronous reset mid-cycle with live requests; outputs must drop before any edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        disp_req  = 1'b1;
        disp_addr = 8'd3;
        game_req  = 1'b1;
        game_we   = 1'b1;
        clr_start = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("rst clr_busy", {31'd0, clr_busy}, 0);
        chk("rst clr_done", {31'd0, clr_done}, 0);
        chk("rst disp_rvalid", {31'd0, disp_rvalid}, 0);
        chk("rst game_rvalid", {31'd0, game_rvalid}, 0);
        chk("rst game_starved", {31'd0, game_starved}, 0);
        chk("rst ram_en", {31'd0, ram_en}, 0);
        chk("rst ram_we", {31'd0, ram_we}, 0);
        chk("rst game_gnt", {31'd0, game_gnt}, 0);
        disp_req = 1'b0;
        game_req = 1'b0;
        game_we  = 1'b0;
        clr_q.delete();
        wait_cnt = 0; exp_done = 0; exp_drv = 0; exp_grv = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    typedef struct {
        bit dr; int da; bit gr; bit gw; int ga; int gd;
        bit e_gnt; bit e_en; bit e_we; int e_addr; bit e_drv; bit e_grv; int e_rd;
    } vec_t;

    vec_t vt [9];
    bit   g, dr, cs, pend, pw;
    int   pa, pd, busy_n, done_n, gnt_n, stall_n, wr_n, nz, first, guard;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        disp_req = 0; disp_addr = 0; game_req = 0; game_we = 0;
        game_addr = 0; game_wdata = 0; clr_start = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    <= DW'(i) ^ 8'hA5;
            shadow[i]  = DW'(i) ^ 8'hA5;
        end
        wait_cnt = 0; exp_done = 0; exp_drv = 0; exp_grv = 0; exp_rdata = '0;
        do_reset();

        // dr da gr gw ga gd | gnt en we addr | drv grv rdata(previous cycle's read)
        vt[0] = '{0,   0, 1, 0,   5,    0,  1, 1, 0,   5,  0, 0, 'h00};
        vt[1] = '{1,   7, 1, 1,   7, 'h3C,  0, 1, 0,   7,  0, 1, 'hA0};
        vt[2] = '{0,   0, 1, 1,   7, 'h3C,  1, 1, 1,   7,  1, 0, 'hA2};
        vt[3] = '{0,   0, 1, 0,   7,    0,  1, 1, 0,   7,  0, 0, 'h00};
        vt[4] = '{1, 250, 0, 0,   0,    0,  0, 1, 0, 250,  0, 1, 'h3C};
        vt[5] = '{0,   0, 1, 0, 230,    0,  1, 1, 0, 230,  1, 0, 'h5F};
        vt[6] = '{0,   0, 0, 0,   0,    0,  0, 0, 0,   0,  0, 1, 'h43};
        vt[7] = '{1,   0, 0, 0,   0,    0,  0, 1, 0,   0,  0, 0, 'h00};
        vt[8] = '{0,   0, 0, 0,   0,    0,  0, 0, 0,   0,  1, 0, 'hA5};
        for (int i = 0; i < 9; i++) begin
            cycle(vt[i].dr, vt[i].da, vt[i].gr, vt[i].gw, vt[i].ga, vt[i].gd, 1'b0, g);
            chk($sformatf("vec%0d gnt", i), {31'd0, game_gnt}, {31'd0, vt[i].e_gnt});
            chk($sformatf("vec%0d en", i), {31'd0, ram_en}, {31'd0, vt[i].e_en});
            if (vt[i].e_en) begin
                chk($sformatf("vec%0d we", i), {31'd0, ram_we}, {31'd0, vt[i].e_we});
                chk($sformatf("vec%0d addr", i), {24'd0, ram_addr}, vt[i].e_addr);
            end
            chk($sformatf("vec%0d disp_rvalid", i), {31'd0, disp_rvalid}, {31'd0, vt[i].e_drv});
            chk($sformatf("vec%0d game_rvalid", i), {31'd0, game_rvalid}, {31'd0, vt[i].e_grv});
            if (vt[i].e_drv || vt[i].e_grv)
                chk($sformatf("vec%0d rdata", i), {24'd0, ram_rdata}, vt[i].e_rd);
        end

        // Full clear with no display traffic and the game knocking throughout.
        cycle(0, 0, 1, 0, 3, 0, 1, g);
        chk("clear start cycle gnt", {31'd0, game_gnt}, 1);
        busy_n = 0; done_n = 0; gnt_n = 0;
        for (int i = 0; i < 260; i++) begin
            cycle(0, 0, 1, 0, 3, 0, 0, g);
            if (clr_busy) busy_n++;
            if (clr_done) done_n++;
            if (clr_busy && game_gnt) gnt_n++;
        end
        chk("clear busy cycles", busy_n, 200);
        chk("clear done pulses", done_n, 1);
        chk("game grants during clear", gnt_n, 0);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] != 8'h00) nz++;
        chk("uncleared cells", nz, 0);
        chk("cell 250 untouched", {24'd0, mem[250]}, 'h5F);

        // Clear with the display stealing every 4th cycle.
        cycle(0, 0, 0, 0, 0, 0, 1, g);
        busy_n = 0; stall_n = 0; wr_n = 0; done_n = 0;
        for (int i = 0; i < 400 && done_n == 0; i++) begin
            dr = (i % 4 == 0);
            cycle(dr, (i * 37) % 256, 0, 0, 0, 0, 0, g);
            if (clr_busy) begin
                busy_n++;
                if (dr) stall_n++;
                if (ram_en && ram_we) wr_n++;
            end
            if (clr_done) done_n++;
        end
        chk("stalled clear done", done_n, 1);
        chk("stalled clear writes", wr_n, 200);
        chk("stalled clear busy cycles", busy_n, 200 + stall_n);

        // Display hogs the RAM for 70 cycles while the game waits.
        first = -1;
        for (int j = 0; j < 70; j++) begin
            cycle(1, j, 1, 1, 9, 'h77, 0, g);
            if (game_starved && first < 0) first = j;
        end
        chk("starve first cycle", first, 64);
        cycle(0, 0, 1, 1, 9, 'h77, 0, g);
        chk("starve grant gnt", {31'd0, game_gnt}, 1);
        chk("starve held on grant", {31'd0, game_starved}, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, g);
        chk("starve after grant", {31'd0, game_starved}, 0);

        // Random mixed traffic against the model.
        pend = 0; pw = 0; pa = 0; pd = 0;
        for (int i = 0; i < 2500; i++) begin
            if (!pend && $urandom_range(1, 0) == 1) begin
                pend = 1;
                pw   = ($urandom_range(1, 0) == 1);
                pa   = int'($urandom_range(255, 0));
                pd   = int'($urandom_range(255, 0));
            end
            dr = ($urandom_range(9, 0) < 3);
            cs = ($urandom_range(299, 0) == 0);
            cycle(dr, int'($urandom_range(255, 0)), pend, pw, pa, pd, cs, g);
            if (g) pend = 0;
        end

        // Reset in the middle of a clear, then a fresh clear from address 0.
        guard = 0;
        cycle(0, 0, 0, 0, 0, 0, 0, g);
        while (clr_busy && guard < 1000) begin
            cycle(0, 0, 0, 0, 0, 0, 0, g);
            guard++;
        end
        chk("drain before reset test", {31'd0, clr_busy}, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, g);
        for (int k = 0; k < 100; k++) cycle(0, 0, 0, 0, 0, 0, 0, g);
        cycle(0, 0, 0, 0, 0, 0, 0, g);
        chk("clear at addr 100", {24'd0, ram_addr}, 100);
        chk("clear writing at 100", {31'd0, ram_we}, 1);
        do_reset();
        done_n = 0;
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, g);
            if (clr_done || clr_busy) done_n++;
        end
        chk("no done or busy after reset", done_n, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, g);
        cycle(0, 0, 0, 0, 0, 0, 0, g);
        chk("restart addr", {24'd0, ram_addr}, 0);
        chk("restart write", {31'd0, ram_en && ram_we}, 1);
        done_n = 0;
        for (int k = 0; k < 300 && done_n == 0; k++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, g);
            if (clr_done) done_n++;
        end
        chk("restarted clear done", done_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
